// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: opcode codes, sequencer states, reset PC, error codes.
package chip8_pkg;

    // Opcode codes produced by the decoder and consumed by sequencer and execute unit.
    localparam logic [4:0] OP_SYS        = 5'd0;
    localparam logic [4:0] OP_DISP_CLR   = 5'd1;
    localparam logic [4:0] OP_RET        = 5'd2;
    localparam logic [4:0] OP_JMP        = 5'd3;
    localparam logic [4:0] OP_CALL       = 5'd4;
    localparam logic [4:0] OP_SE_VX_NN   = 5'd5;
    localparam logic [4:0] OP_SNE_VX_NN  = 5'd6;
    localparam logic [4:0] OP_SE_VX_VY   = 5'd7;
    localparam logic [4:0] OP_LD_VX_NN   = 5'd8;
    localparam logic [4:0] OP_ADD_VX_NN  = 5'd9;
    localparam logic [4:0] OP_LD_VX_VY   = 5'd10;
    localparam logic [4:0] OP_OR_VX_VY   = 5'd11;
    localparam logic [4:0] OP_AND_VX_VY  = 5'd12;
    localparam logic [4:0] OP_XOR_VX_VY  = 5'd13;
    localparam logic [4:0] OP_ADD_VX_VY  = 5'd14;
    localparam logic [4:0] OP_SUB_VX_VY  = 5'd15;
    localparam logic [4:0] OP_SHR_VX     = 5'd16;
    localparam logic [4:0] OP_SUBN_VX_VY = 5'd17;
    localparam logic [4:0] OP_SHL_VX     = 5'd18;
    localparam logic [4:0] OP_SNE_VX_VY  = 5'd19;
    localparam logic [4:0] OP_LD_I_ADDR  = 5'd20;
    localparam logic [4:0] OP_JMP_V0_ADDR = 5'd21;
    localparam logic [4:0] OP_RND_VX_NN  = 5'd22;
    localparam logic [4:0] OP_DRW        = 5'd23;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_HI,
        ST_FETCH_LO,
        ST_LATCH,
        ST_DECODE,
        ST_DISPATCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    // Program counter after reset (CHIP-8 programs load at 0x200).
    localparam logic [11:0] PC_RESET = 12'h200;

    // Sticky fault codes reported on err_code.
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

endpackage

// File: rtl/call_stack.sv
// Return-address stack for CALL/RET. Push and pop are never requested together.
module call_stack #(
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [11:0] i_push_data,
    output logic [11:0] o_top,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [11:0]    r_mem [DEPTH];
    logic [SPW-1:0] r_sp;

    // Stack pointer: counts valid entries, so full means sp == DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_sp <= '0;
        end else if (i_push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (i_pop) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; entries above sp are never read, and leaving
        // it unreset lets it map onto plain storage instead of 16 resettable flops.
        if (i_push) begin
            r_mem[AW'(r_sp)] <= i_push_data;
        end
    end

    assign o_top   = r_mem[AW'(r_sp - SPW'(1))];
    assign o_full  = (r_sp == SPW'(DEPTH));
    assign o_empty = (r_sp == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// CHIP-8 instruction sequencer: fetches two-byte opcodes, resolves jumps, calls,
// returns and PC locally, and hands all other opcodes to the execute unit.
module fetch_sequencer #(
    parameter logic [11:0] PC_RESET    = chip8_pkg::PC_RESET,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [15:0] instruction,
    input  logic [4:0]  decode,
    input  logic [11:0] addr_in,
    input  logic [7:0]  v0,
    output logic        exec_valid,
    output logic [4:0]  exec_code,
    input  logic        exec_done,
    input  logic        exec_skip,
    output logic [11:0] pc,
    output logic        halted,
    output logic [1:0]  err_code
);

    import chip8_pkg::*;

    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    state_t      r_state;
    logic [11:0] r_pc;
    logic [15:0] r_instruction;
    logic        r_exec_valid;
    logic [4:0]  r_exec_code;
    logic        r_halted;
    logic [1:0]  r_err_code;

    logic        w_dispatch;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [11:0] w_top;
    logic [11:0] w_pc_next_seq;
    logic [11:0] w_pc_after_exec;
    state_t      w_boundary_state;

    assign w_dispatch       = (r_state == ST_DISPATCH);
    assign w_push           = w_dispatch && (decode == OP_CALL) && !w_full;
    assign w_pop            = w_dispatch && (decode == OP_RET) && !w_empty;
    assign w_pc_next_seq    = r_pc + 12'd2;
    assign w_pc_after_exec  = r_pc + (exec_skip ? 12'd4 : 12'd2);
    // run is only looked at here, at instruction boundaries.
    assign w_boundary_state = run ? ST_FETCH_HI : ST_IDLE;

    call_stack #(
        .DEPTH (STACK_DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_next_seq),
        .o_top       (w_top),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Sequencer FSM: fetch, latch, decode wait, local control flow or dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= PC_RESET;
            r_instruction <= '0;
            r_exec_valid  <= 1'b0;
            r_exec_code   <= '0;
            r_halted      <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_FETCH_HI;
                end
                ST_FETCH_HI: r_state <= ST_FETCH_LO;
                ST_FETCH_LO: begin
                    r_instruction[15:8] <= mem_data;
                    r_state             <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_instruction[7:0] <= mem_data;
                    r_state            <= ST_DECODE;
                end
                ST_DECODE: r_state <= ST_DISPATCH;
                ST_DISPATCH: begin
                    r_state <= w_boundary_state;
                    case (decode)
                        OP_JMP:         r_pc <= addr_in;
                        OP_JMP_V0_ADDR: r_pc <= addr_in + {4'h0, v0};
                        OP_CALL: begin
                            if (w_full) begin
                                r_halted   <= 1'b1;
                                r_err_code <= ERR_OVERFLOW;
                                r_state    <= ST_HALT;
                            end else begin
                                r_pc <= addr_in;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                r_halted   <= 1'b1;
                                r_err_code <= ERR_UNDERFLOW;
                                r_state    <= ST_HALT;
                            end else begin
                                r_pc <= w_top;
                            end
                        end
                        OP_SYS: r_pc <= w_pc_next_seq;
                        default: begin
                            r_exec_valid <= 1'b1;
                            r_exec_code  <= decode;
                            r_state      <= ST_EXEC;
                        end
                    endcase
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        r_exec_valid <= 1'b0;
                        r_pc         <= w_pc_after_exec;
                        r_state      <= w_boundary_state;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr    = (r_state == ST_FETCH_LO) ? (r_pc + 12'd1) : r_pc;
    assign mem_rd      = (r_state == ST_FETCH_HI) || (r_state == ST_FETCH_LO);
    assign instruction = r_instruction;
    assign exec_valid  = r_exec_valid;
    assign exec_code   = r_exec_code;
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a RAM model and a registered decoder model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [15:0] instruction;
    logic [4:0]  decode;
    logic [11:0] addr_in;
    logic [7:0]  v0;
    logic        exec_valid;
    logic [4:0]  exec_code;
    logic        exec_done;
    logic        exec_skip;
    logic [11:0] pc;
    logic        halted;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [4096];

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .instruction (instruction),
        .decode      (decode),
        .addr_in     (addr_in),
        .v0          (v0),
        .exec_valid  (exec_valid),
        .exec_code   (exec_code),
        .exec_done   (exec_done),
        .exec_skip   (exec_skip),
        .pc          (pc),
        .halted      (halted),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Minimal decoder: enough opcode classes for the directed programs below.
    function automatic logic [4:0] dec(input logic [15:0] ins);
        case (ins[15:12])
            4'h0:    dec = (ins == 16'h00E0) ? 5'd1 : (ins == 16'h00EE) ? 5'd2 : 5'd0;
            4'h1:    dec = 5'd3;
            4'h2:    dec = 5'd4;
            4'h3:    dec = 5'd5;
            4'hB:    dec = 5'd21;
            default: dec = 5'd8;
        endcase
    endfunction

    // RAM returns data one cycle after the read strobe; decoder registers one cycle after instruction.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
        decode  <= dec(instruction);
        addr_in <= instruction[11:0];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    endtask

    // Reset for two cycles, then release with run=1; the next negedge is FETCH_HI of 0x200.
    task automatic start();
        rst = 1'b1; run = 1'b0; exec_done = 1'b0; exec_skip = 1'b0;
        cyc(2);
        rst = 1'b0; run = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; exec_done = 1'b0; exec_skip = 1'b0; v0 = 8'h20;
        cyc(2);
        checks++; if (pc !== 12'h200) begin failures++; $display("FAIL rst_pc got=%h exp=200", pc); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL rst_instruction got=%h exp=0000", instruction); end
        checks++; if (exec_valid !== 1'b0 || exec_code !== 5'd0) begin failures++; $display("FAIL rst_exec got=%b/%0d exp=0/0", exec_valid, exec_code); end
        checks++; if (halted !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL rst_err got=%b/%b exp=0/00", halted, err_code); end
        rst = 1'b0; run = 1'b0;
        cyc(2);
        checks++; if (mem_rd !== 1'b0 || mem_addr !== 12'h200) begin failures++; $display("FAIL idle_park got rd=%b addr=%h exp rd=0 addr=200", mem_rd, mem_addr); end
    endtask

    task automatic test_jump();
        int ev_seen;
        clear_ram();
        ram[12'h200] = 8'h12; ram[12'h201] = 8'h34;
        ram[12'h234] = 8'h12; ram[12'h235] = 8'h34;
        start();
        ev_seen = 0;
        cyc(1);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h200) begin failures++; $display("FAIL jmp_fetch_hi got rd=%b addr=%h exp rd=1 addr=200", mem_rd, mem_addr); end
        cyc(1); ev_seen += int'(exec_valid);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h201) begin failures++; $display("FAIL jmp_fetch_lo got rd=%b addr=%h exp rd=1 addr=201", mem_rd, mem_addr); end
        cyc(2); ev_seen += int'(exec_valid);
        checks++; if (instruction !== 16'h1234) begin failures++; $display("FAIL jmp_instruction got=%h exp=1234", instruction); end
        cyc(1); ev_seen += int'(exec_valid);
        checks++; if (pc !== 12'h200) begin failures++; $display("FAIL jmp_pc_dispatch got=%h exp=200", pc); end
        cyc(1);
        checks++; if (pc !== 12'h234 || mem_addr !== 12'h234 || mem_rd !== 1'b1) begin failures++; $display("FAIL jmp_refetch got pc=%h addr=%h rd=%b exp 234/234/1", pc, mem_addr, mem_rd); end
        for (int i = 0; i < 5; i++) begin cyc(1); ev_seen += int'(exec_valid); end
        checks++; if (ev_seen != 0) begin failures++; $display("FAIL jmp_no_exec got=%0d exp=0", ev_seen); end
    endtask

    task automatic test_call_ret();
        clear_ram();
        ram[12'h200] = 8'h23; ram[12'h201] = 8'h00;   // CALL 0x300
        ram[12'h300] = 8'h00; ram[12'h301] = 8'hEE;   // RET
        ram[12'h202] = 8'h00; ram[12'h203] = 8'hEE;   // RET with empty stack
        start();
        cyc(6);
        checks++; if (pc !== 12'h300 || mem_addr !== 12'h300) begin failures++; $display("FAIL call_pc got=%h exp=300", pc); end
        cyc(5);
        checks++; if (pc !== 12'h202 || halted !== 1'b0) begin failures++; $display("FAIL ret_pc got=%h halted=%b exp=202/0", pc, halted); end
        cyc(5);
        checks++; if (halted !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL underflow got=%b/%b exp=1/10", halted, err_code); end
        checks++; if (pc !== 12'h202 || mem_rd !== 1'b0) begin failures++; $display("FAIL underflow_hold got pc=%h rd=%b exp 202/0", pc, mem_rd); end
    endtask

    task automatic test_exec();
        clear_ram();
        ram[12'h200] = 8'h12; ram[12'h201] = 8'h10;   // JMP 0x210
        ram[12'h210] = 8'h31; ram[12'h211] = 8'h22;   // code 5
        ram[12'h214] = 8'h12; ram[12'h215] = 8'h10;   // JMP 0x210
        start();
        cyc(6);
        checks++; if (pc !== 12'h210) begin failures++; $display("FAIL exec_pre_pc got=%h exp=210", pc); end
        cyc(4);
        checks++; if (exec_valid !== 1'b0) begin failures++; $display("FAIL exec_early got=%b exp=0", exec_valid); end
        cyc(1);
        checks++; if (exec_valid !== 1'b1 || exec_code !== 5'd5) begin failures++; $display("FAIL exec_c1 got=%b/%0d exp=1/5", exec_valid, exec_code); end
        cyc(1);
        checks++; if (exec_valid !== 1'b1 || exec_code !== 5'd5) begin failures++; $display("FAIL exec_c2 got=%b/%0d exp=1/5", exec_valid, exec_code); end
        cyc(1);
        checks++; if (exec_valid !== 1'b1 || pc !== 12'h210) begin failures++; $display("FAIL exec_c3 got=%b pc=%h exp=1/210", exec_valid, pc); end
        exec_done = 1'b1; exec_skip = 1'b1;
        cyc(1);
        checks++; if (exec_valid !== 1'b0 || pc !== 12'h214 || mem_addr !== 12'h214 || mem_rd !== 1'b1) begin failures++; $display("FAIL exec_skip got v=%b pc=%h addr=%h rd=%b exp 0/214/214/1", exec_valid, pc, mem_addr, mem_rd); end
        // exec_done stays high through the next fetch; it must be ignored outside EXEC.
        exec_skip = 1'b0;
        cyc(5);
        checks++; if (pc !== 12'h210 || exec_valid !== 1'b0) begin failures++; $display("FAIL exec_done_ignored got pc=%h v=%b exp 210/0", pc, exec_valid); end
        cyc(5);
        checks++; if (exec_valid !== 1'b1 || exec_code !== 5'd5) begin failures++; $display("FAIL exec_zero_wait_c1 got=%b/%0d exp=1/5", exec_valid, exec_code); end
        cyc(1);
        checks++; if (exec_valid !== 1'b0 || pc !== 12'h212) begin failures++; $display("FAIL exec_noskip got v=%b pc=%h exp 0/212", exec_valid, pc); end
        exec_done = 1'b0;
    endtask

    task automatic test_overflow();
        int rd_seen;
        clear_ram();
        ram[12'h200] = 8'h24; ram[12'h201] = 8'h00;   // CALL 0x400
        ram[12'h400] = 8'h24; ram[12'h401] = 8'h00;   // CALL 0x400 (recursive)
        start();
        cyc(81);
        checks++; if (pc !== 12'h400 || halted !== 1'b0) begin failures++; $display("FAIL ovf_before got pc=%h halted=%b exp 400/0", pc, halted); end
        cyc(5);
        checks++; if (halted !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL overflow got=%b/%b exp=1/01", halted, err_code); end
        checks++; if (pc !== 12'h400) begin failures++; $display("FAIL ovf_pc got=%h exp=400", pc); end
        rd_seen = 0;
        for (int i = 0; i < 8; i++) begin cyc(1); rd_seen += int'(mem_rd) + int'(exec_valid); end
        checks++; if (rd_seen != 0) begin failures++; $display("FAIL halt_quiet got=%0d exp=0", rd_seen); end
        rst = 1'b1;
        cyc(1);
        checks++; if (pc !== 12'h200 || halted !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL halt_rst got pc=%h h=%b e=%b exp 200/0/00", pc, halted, err_code); end
        rst = 1'b0; run = 1'b0;
    endtask

    task automatic test_wrap();
        clear_ram();
        ram[12'h200] = 8'hBF; ram[12'h201] = 8'hF0;   // JMP V0+0xFF0
        ram[12'h010] = 8'h1F; ram[12'h011] = 8'hFF;   // JMP 0xFFF
        ram[12'hFFF] = 8'h10; ram[12'h000] = 8'h50;   // JMP 0x050, split across the wrap
        ram[12'h050] = 8'h10; ram[12'h051] = 8'h50;
        v0 = 8'h20;
        start();
        cyc(6);
        checks++; if (pc !== 12'h010) begin failures++; $display("FAIL jmp_v0_wrap got=%h exp=010", pc); end
        cyc(5);
        checks++; if (pc !== 12'hFFF) begin failures++; $display("FAIL jmp_fff got=%h exp=fff", pc); end
        cyc(1);
        checks++; if (mem_addr !== 12'h000 || mem_rd !== 1'b1) begin failures++; $display("FAIL addr_wrap got=%h rd=%b exp 000/1", mem_addr, mem_rd); end
        cyc(2);
        checks++; if (instruction !== 16'h1050) begin failures++; $display("FAIL wrap_instruction got=%h exp=1050", instruction); end
        cyc(2);
        checks++; if (pc !== 12'h050) begin failures++; $display("FAIL wrap_jmp got=%h exp=050", pc); end
    endtask

    task automatic test_run_drop();
        clear_ram();
        ram[12'h200] = 8'h31; ram[12'h201] = 8'h00;   // code 5
        ram[12'h202] = 8'h31; ram[12'h203] = 8'h00;   // code 5
        start();
        cyc(6);
        checks++; if (exec_valid !== 1'b1) begin failures++; $display("FAIL drop_exec_c1 got=%b exp=1", exec_valid); end
        run = 1'b0;
        cyc(1);
        checks++; if (exec_valid !== 1'b1) begin failures++; $display("FAIL drop_exec_held got=%b exp=1", exec_valid); end
        exec_done = 1'b1; exec_skip = 1'b0;
        cyc(1);
        exec_done = 1'b0;
        checks++; if (exec_valid !== 1'b0 || pc !== 12'h202 || mem_rd !== 1'b0) begin failures++; $display("FAIL drop_done got v=%b pc=%h rd=%b exp 0/202/0", exec_valid, pc, mem_rd); end
        cyc(3);
        checks++; if (mem_rd !== 1'b0 || pc !== 12'h202) begin failures++; $display("FAIL drop_parked got rd=%b pc=%h exp 0/202", mem_rd, pc); end
        run = 1'b1;
        cyc(1);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 12'h202) begin failures++; $display("FAIL resume got rd=%b addr=%h exp 1/202", mem_rd, mem_addr); end
        cyc(5);
        checks++; if (exec_valid !== 1'b1 || pc !== 12'h202) begin failures++; $display("FAIL second_exec got v=%b pc=%h exp 1/202", exec_valid, pc); end
        rst = 1'b1;
        cyc(1);
        checks++; if (exec_valid !== 1'b0 || exec_code !== 5'd0 || pc !== 12'h200 || mem_rd !== 1'b0) begin failures++; $display("FAIL rst_mid_exec got v=%b c=%0d pc=%h rd=%b exp 0/0/200/0", exec_valid, exec_code, pc, mem_rd); end
        rst = 1'b0; run = 1'b0;
    endtask

    initial begin
        clear_ram();
        test_reset();
        test_jump();
        test_call_ret();
        test_exec();
        test_overflow();
        test_wrap();
        test_run_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
